tqv_bus_arbiter: RTL
====================

# tqv_bus_arbiter

Two-master arbiter for the TinyQV peripheral data bus. It shares the single peripheral-side bus between the CPU (master 0) and a debug/DMA master (master 1), and replaces simulation-only bus forcing with a synthesizable path. Requests are granted round-robin. Master 1 can lock the bus across multi-access sequences. A watchdog terminates any transfer that the peripheral never acknowledges.

## Interface
Parameters:
- TIMEOUT, 255 — cycles without `s_ready` before a granted transfer is aborted (1..255)
- ADDR_W, 28 — address width

Ports (m0_* and m1_* sets are identical):
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- mX_addr  in  ADDR_W  request address
- mX_write_n  in  2  write size: 00 byte, 01 half, 10 word, 11 none
- mX_read_n  in  2  read size, same encoding
- mX_wdata  in  32  write data
- m1_lock  in  1  keep the grant with master 1 after its transfer completes
- mX_ready  out  1  one-cycle pulse that completes mX's transfer
- mX_err  out  1  qualifies mX_ready; 1 = watchdog abort
- m_rdata  out  32  read data for the master being acknowledged
- s_addr  out  ADDR_W  peripheral address (registered)
- s_write_n  out  2  peripheral write strobe (registered)
- s_read_n  out  2  peripheral read strobe (registered)
- s_wdata  out  32  peripheral write data (registered)
- s_ready  in  1  peripheral completion
- s_rdata  in  32  peripheral read data, valid with s_ready
- owner  out  1  current/last grantee

## Operation
- Request: `reqX = (mX_write_n != 11) | (mX_read_n != 11)`. A master holds its request fields stable until `mX_ready`. Asserting write and read together is illegal and is not checked.
- States: IDLE, GNT0, GNT1, HOLD1.
- IDLE:
  - If only one master requests, grant it.
  - If both request, grant the master that is not `owner` (round-robin).
  - Entering GNTx loads `s_*` from mX and clears the watchdog.
- GNTx:
  - `s_*` hold their values.
  - The watchdog increments each cycle.
- Completion in GNTx, when `s_ready=1` or `watchdog==TIMEOUT-1`:
  - `mX_ready=1` combinationally.
  - `mX_err = ~s_ready`.
  - `m_rdata = s_ready ? s_rdata : 0`.
  - The completing master's request is ignored during that cycle.
  - Next state: if X=1 and `m1_lock`, go to HOLD1. Otherwise, if the other master requests, go directly to its GNT. Otherwise go to IDLE.
- HOLD1:
  - Strobes are at 11. m0 is blocked.
  - `req1` goes to GNT1.
  - `~m1_lock & ~req1` goes to IDLE.
  - `~m1_lock & req1` still goes to GNT1 (one last access).
- `s_write_n`/`s_read_n` are 11 in IDLE and HOLD1 and on the edge after completion, unless a new grant loads them.
- `owner` updates on each grant entry.
- Any ready or err output outside a GNT-state completion is 0.

## Timing
- Reset (async assert) puts the block in this state:
  - state IDLE
  - `s_addr` 0, `s_wdata` 0, `s_write_n`/`s_read_n` 11
  - `owner` 1, so m0 wins the first tie
  - `mX_ready` 0, `mX_err` 0, `m_rdata` 0
  - watchdog 0
  - Reset mid-transfer drops the strobes immediately. No ready is issued.
- Latency:
  - Request seen in cycle N (IDLE) → strobes valid in cycle N+1.
  - The earliest ready is cycle N+1 (`s_ready` combinational passthrough).
- Back-to-back: two alternating masters with a zero-wait peripheral get one transfer per cycle, with no idle cycle between them. The same master gets one transfer every 2 cycles (via IDLE).
- Simultaneous `s_ready` and watchdog expiry: `s_ready` wins and err=0.
- `s_ready` in IDLE or HOLD1 is ignored.
- Watchdog abort occurs exactly TIMEOUT cycles after the strobes first appear. The strobe is asserted for TIMEOUT cycles.

## Structure
- Package `tqv_bus_pkg`:
  - state enum
  - `STROBE_IDLE = 2'b11`
  - size encodings
  - default ADDR_W
- Sub-module `tqv_bus_watchdog`: 8-bit counter with clear/enable inputs and an `expire` output at TIMEOUT-1.
- Arbiter FSM, request mux and output registers are kept in `tqv_bus_arbiter`.

## Test plan
- Reset then idle: after `rst_n` rises with no requests, outputs stay at reset values for 10 cycles; `owner=1`.
- Single write: m0 writes word 0xDEADBEEF to 0x800_0010, peripheral acks after 2 cycles → `s_write_n=10` in cycles 1–3; `m0_ready` pulses in cycle 3 with `m0_err=0`; strobes return to 11 in cycle 4.
- Contention: m0 and m1 request in the same cycle with zero-wait acks → grants go m0, m1, m0, m1 on consecutive cycles, with no idle strobe cycle between them.
- Lock: m1 reads with `m1_lock=1` while m0 requests; m1 issues 3 more reads → m0 is not granted until `m1_lock` drops and HOLD1 exits; then m0 is granted the next cycle.
- Timeout: with TIMEOUT=4, m1 reads and `s_ready` is held at 0 → `m1_ready=1`, `m1_err=1`, `m_rdata=0` in the 4th strobe cycle; `s_ready` rising in that same cycle instead gives err=0 with `s_rdata` passed through.
- Async reset mid-transfer: `rst_n` is dropped in cycle 2 of GNT0 → strobes go to 11 without waiting for a clock edge and no `m0_ready` is issued; after release the block is in IDLE and a new m0 request is granted normally.

Source files
------------

// File: rtl/tqv_bus_pkg.sv
// tqv_bus_pkg: shared constants for the TinyQV two-master peripheral bus arbiter
package tqv_bus_pkg;

    localparam int ADDR_W_DEF = 28;

    localparam logic [1:0] STROBE_IDLE = 2'b11;
    localparam logic [1:0] SZ_BYTE     = 2'b00;
    localparam logic [1:0] SZ_HALF     = 2'b01;
    localparam logic [1:0] SZ_WORD     = 2'b10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GNT0  = 2'd1;
    localparam logic [1:0] ST_GNT1  = 2'd2;
    localparam logic [1:0] ST_HOLD1 = 2'd3;

endpackage

// File: rtl/tqv_bus_watchdog.sv
// tqv_bus_watchdog: counts cycles of an outstanding transfer and flags the last allowed cycle
module tqv_bus_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;

    // clear on a new grant takes priority over counting
    always_comb cnt_d = clr_i ? 8'd0 : en_i ? cnt_q + 8'd1 : cnt_q;

    // counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 8'd0;
        else        cnt_q <= cnt_d;
    end

    assign expire_o = cnt_q == LAST;

endmodule

// File: rtl/tqv_bus_arbiter.sv
// tqv_bus_arbiter: round-robin two-master arbiter with m1 bus lock and transfer watchdog
module tqv_bus_arbiter
    import tqv_bus_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [1:0]        m0_write_n,
    input  logic [1:0]        m0_read_n,
    input  logic [31:0]       m0_wdata,
    output logic              m0_ready,
    output logic              m0_err,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [1:0]        m1_write_n,
    input  logic [1:0]        m1_read_n,
    input  logic [31:0]       m1_wdata,
    input  logic              m1_lock,
    output logic              m1_ready,
    output logic              m1_err,
    output logic [31:0]       m_rdata,
    output logic [ADDR_W-1:0] s_addr,
    output logic [1:0]        s_write_n,
    output logic [1:0]        s_read_n,
    output logic [31:0]       s_wdata,
    input  logic              s_ready,
    input  logic [31:0]       s_rdata,
    output logic              owner
);

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] s_addr_q, s_addr_d;
    logic [1:0]        s_write_n_q, s_write_n_d, s_read_n_q, s_read_n_d;
    logic [31:0]       s_wdata_q, s_wdata_d;
    logic              req0, req1, gnt0, gnt1, expire, done, load, sel;

    assign req0 = (m0_write_n != STROBE_IDLE) | (m0_read_n != STROBE_IDLE);
    assign req1 = (m1_write_n != STROBE_IDLE) | (m1_read_n != STROBE_IDLE);
    assign gnt0 = state_q == ST_GNT0;
    assign gnt1 = state_q == ST_GNT1;
    assign done = (gnt0 | gnt1) & (s_ready | expire);

    assign m0_ready = gnt0 & done;
    assign m1_ready = gnt1 & done;
    assign m0_err   = m0_ready & ~s_ready;
    assign m1_err   = m1_ready & ~s_ready;
    assign m_rdata  = (done & s_ready) ? s_rdata : 32'd0;

    tqv_bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (load),
        .en_i     (gnt0 | gnt1),
        .expire_o (expire)
    );

    // round-robin from IDLE, direct hand-over on completion, HOLD1 keeps the bus for m1
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = (req0 & req1) ? (owner_q ? ST_GNT0 : ST_GNT1) :
                               req0 ? ST_GNT0 : req1 ? ST_GNT1 : ST_IDLE;
            ST_GNT0: state_d = ~done ? ST_GNT0 : req1 ? ST_GNT1 : ST_IDLE;
            ST_GNT1: state_d = ~done ? ST_GNT1 : m1_lock ? ST_HOLD1 : req0 ? ST_GNT0 : ST_IDLE;
            default: state_d = req1 ? ST_GNT1 : m1_lock ? ST_HOLD1 : ST_IDLE;
        endcase
    end

    assign load = ((state_d == ST_GNT0) & ~gnt0) | ((state_d == ST_GNT1) & ~gnt1);
    assign sel  = state_d == ST_GNT1;

    // peripheral-side registers load on grant entry and drop strobes after completion
    always_comb begin
        s_addr_d    = load ? (sel ? m1_addr : m0_addr) : s_addr_q;
        s_wdata_d   = load ? (sel ? m1_wdata : m0_wdata) : s_wdata_q;
        s_write_n_d = load ? (sel ? m1_write_n : m0_write_n) : done ? STROBE_IDLE : s_write_n_q;
        s_read_n_d  = load ? (sel ? m1_read_n : m0_read_n) : done ? STROBE_IDLE : s_read_n_q;
        owner_d     = load ? sel : owner_q;
    end

    // state and output registers; reset drops the strobes immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b1;
            s_addr_q    <= '0;
            s_wdata_q   <= 32'd0;
            s_write_n_q <= STROBE_IDLE;
            s_read_n_q  <= STROBE_IDLE;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            s_addr_q    <= s_addr_d;
            s_wdata_q   <= s_wdata_d;
            s_write_n_q <= s_write_n_d;
            s_read_n_q  <= s_read_n_d;
        end
    end

    assign s_addr    = s_addr_q;
    assign s_wdata   = s_wdata_q;
    assign s_write_n = s_write_n_q;
    assign s_read_n  = s_read_n_q;
    assign owner     = owner_q;

endmodule
